stencil_buffer: RTL and testbench
=================================

Name: stencil_buffer

Overview:
- On-chip pixel store for one stencil (sprite) image of IN_HWIDTH x IN_VWIDTH pixels, DATA_WIDTH bits per pixel.
- Loaded through a write port (in_address/in_data/we) and read through a registered read port (out_address -> out_data).
- Sits inside the stencil drawing block. The drawing sequencer fills it, then scans it to produce pixels for the frame buffer.

Parameters:
- DATA_WIDTH, 12, bits per pixel (4:4:4 RGB).
- IN_HWIDTH, 20, stencil width in pixels.
- IN_VWIDTH, 40, stencil height in pixels.
- IN_ADDR_WIDTH, 11, write-address width.
- OUT_ADDR_WIDTH, 20, read-address width.
- DEPTH, IN_HWIDTH*IN_VWIDTH (800), number of stored pixels.

Ports:
- clock  input  1  single clock; all sequential logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- out_data  output  DATA_WIDTH  registered read data.
- out_address  input  OUT_ADDR_WIDTH  linear read index (row*IN_HWIDTH + col).
- in_data  input  DATA_WIDTH  write data.
- in_address  input  IN_ADDR_WIDTH  linear write index (row*IN_HWIDTH + col).
- we  input  1  write enable, active high.

Behaviour:
- Storage: DEPTH words of DATA_WIDTH bits.
  - Contents are not affected by reset and are undefined after power-up until written.
  - Must be inferable as block or distributed RAM: no reset on the array.
- Write: on a rising clock edge with we=1 and in_address < DEPTH, mem[in_address] <= in_data.
  - When in_address >= DEPTH, the write is silently dropped and no other word changes.
- Read: synchronous, 1-cycle latency. Every rising edge out_data <= mem[out_address] when out_address < DEPTH, else 0.
  - The read port is always active and independent of we.
- Read-during-write, same address: read-first. out_data returns the old word; the new word is visible from the next read.
- Read-during-write, different addresses: both operations complete in the same cycle.
- Reset (reset_n=0, asynchronous assertion): out_data = 0 immediately and is held at 0 while reset is asserted.
  - Writes are ignored during reset.
  - Reads resume on the first rising edge after deassertion.
  - Reset deasserts synchronously to clock (handled upstream).
- Reset mid-load: previously written words keep their values; only out_data is cleared.
- Widths:
  - Address comparisons are unsigned at full port width.
  - Upper out_address bits above clog2(DEPTH) take part in the range check. For example, 20'h00400 (1024) reads 0.
- No internal state machine; no handshake beyond we. Back-to-back writes are allowed every cycle.

Decomposition:
- Shared package stencil_pkg holds:
  - DATA_WIDTH, IN_HWIDTH, IN_VWIDTH, IN_ADDR_WIDTH, OUT_ADDR_WIDTH, DEPTH.
  - A pixel_t typedef (DATA_WIDTH bits).
  - TRANSPARENT_PIXEL = 0, the out-of-range read value.
- One natural sub-module, stencil_ram: a plain simple-dual-port RAM with read-first behaviour.
  - stencil_buffer wraps it with the address range checks, the out-of-range zero mux and the out_data reset register.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with out_data nonzero -> out_data=0 without waiting for a clock edge; stays 0 until reset is released.
- Fill and readback:
  - Write mem[i]=i^12'hA5A for i=0..799 (we=1, one per cycle).
  - Then read i=0..799 -> out_data equals the written value exactly one cycle after each address is presented.
- Bounds:
  - Write in_address=800 with 12'hFFF -> mem[0..799] unchanged.
  - Read out_address=800 and 20'hFFFFF -> out_data=0.
- Read-during-write:
  - mem[5]=12'h111, then in the same cycle write 12'h222 to 5 and read 5 -> out_data=12'h111.
  - Next read of 5 -> 12'h222.
- Write disabled: in_address=10, in_data=12'h333, we=0 for several cycles -> mem[10] keeps its prior value.
- Reset mid-load:
  - Write addresses 0..99, pulse reset_n low, write 100..799.
  - Full readback matches all written values; out_data=0 during reset.

Source files
------------

// File: rtl/stencil_pkg.sv
// Shared sizing and pixel type for the stencil drawing block.
// Stencil geometry is fixed here so every stage agrees on it.
package stencil_pkg;

  localparam int DATA_WIDTH     = 12;
  localparam int IN_HWIDTH      = 20;
  localparam int IN_VWIDTH      = 40;
  localparam int IN_ADDR_WIDTH  = 11;
  localparam int OUT_ADDR_WIDTH = 20;
  localparam int DEPTH          = IN_HWIDTH * IN_VWIDTH;
  localparam int RAM_ADDR_WIDTH = $clog2(DEPTH);

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  localparam pixel_t TRANSPARENT_PIXEL = '0;

endpackage

// File: rtl/stencil_ram.sv
// Simple dual-port RAM, one write and one registered read port, read-first.
// No reset on the array or the read register so it maps onto block/distributed RAM.
module stencil_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 800,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Both assignments are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stencil_buffer.sv
// Stencil pixel store: range-checked writes, 1-cycle registered reads that
// return TRANSPARENT_PIXEL out of range, and out_data forced to zero in reset.
module stencil_buffer
  import stencil_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset_n,
  output pixel_t                    out_data,
  input  logic [OUT_ADDR_WIDTH-1:0] out_address,
  input  pixel_t                    in_data,
  input  logic [IN_ADDR_WIDTH-1:0]  in_address,
  input  logic                      we
);

  localparam logic [IN_ADDR_WIDTH-1:0]  IN_LIMIT  = IN_ADDR_WIDTH'(DEPTH);
  localparam logic [OUT_ADDR_WIDTH-1:0] OUT_LIMIT = OUT_ADDR_WIDTH'(DEPTH);

  logic                      wr_in_range;
  logic                      rd_in_range;
  logic                      wr_en;
  logic [RAM_ADDR_WIDTH-1:0] rd_addr;
  pixel_t                    rd_data;
  logic                      rd_valid_q;

  // Full-width compares so high address bits cannot alias into the array.
  assign wr_in_range = (in_address < IN_LIMIT);
  assign rd_in_range = (out_address < OUT_LIMIT);
  assign wr_en       = we && wr_in_range && reset_n;
  assign rd_addr     = rd_in_range ? out_address[RAM_ADDR_WIDTH-1:0] : '0;

  stencil_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (RAM_ADDR_WIDTH)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (in_address[RAM_ADDR_WIDTH-1:0]),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // The RAM read register has no reset; this flag gates it so reset clears
  // out_data asynchronously and out-of-range reads return transparent.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_in_range;
    end
  end

  assign out_data = rd_valid_q ? rd_data : TRANSPARENT_PIXEL;

endmodule

// File: tb/tb_stencil_buffer.sv
// Directed bench for stencil_buffer: inputs change after the falling edge,
// outputs are checked on the following falling edge against a local memory model.
module tb_stencil_buffer;
  import stencil_pkg::*;

  logic                      clock;
  logic                      reset_n;
  pixel_t                    out_data;
  logic [OUT_ADDR_WIDTH-1:0] out_address;
  pixel_t                    in_data;
  logic [IN_ADDR_WIDTH-1:0]  in_address;
  logic                      we;

  pixel_t                    exp_mem [DEPTH];
  logic [DATA_WIDTH-1:0]     exp_q [$];
  int                        n_cmp;
  int                        n_err;

  stencil_buffer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .out_data    (out_data),
    .out_address (out_address),
    .in_data     (in_data),
    .in_address  (in_address),
    .we          (we)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input pixel_t got, input pixel_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  // driver tasks: called at a falling edge, return at the next falling edge
  task automatic write_word(input int addr, input pixel_t data);
    in_address = IN_ADDR_WIDTH'(addr);
    in_data    = data;
    we         = 1'b1;
    @(negedge clock);
    we         = 1'b0;
    if (addr < DEPTH) exp_mem[addr] = data;
  endtask

  task automatic read_check(input string tag, input logic [OUT_ADDR_WIDTH-1:0] addr);
    out_address = addr;
    if (addr < OUT_ADDR_WIDTH'(DEPTH)) exp_q.push_back(exp_mem[int'(addr)]);
    else                               exp_q.push_back(TRANSPARENT_PIXEL);
    @(negedge clock);
    check(tag, out_data, exp_q.pop_front());
  endtask

  task automatic readback_all(input string tag);
    for (int i = 0; i < DEPTH; i++) read_check(tag, OUT_ADDR_WIDTH'(i));
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset_n     = 1'b0;
    we          = 1'b0;
    in_address  = '0;
    in_data     = '0;
    out_address = '0;
    repeat (3) @(negedge clock);
    check("reset_out", out_data, 12'h000);
    reset_n = 1'b1;

    // fill and readback, plus out-of-range writes that must be dropped
    for (int i = 0; i < DEPTH; i++) write_word(i, 12'(i) ^ 12'hA5A);
    in_address = 11'd800;  in_data = 12'hFFF; we = 1'b1; @(negedge clock);
    in_address = 11'h7FF;  in_data = 12'hFFF;            @(negedge clock);
    we = 1'b0;
    readback_all("fill_rd");

    read_check("oor_800",   20'd800);
    read_check("oor_1024",  20'h00400);
    read_check("oor_fffff", 20'hFFFFF);
    read_check("last_799",  20'd799);

    // asynchronous reset with nonzero out_data
    read_check("pre_rst", 20'd1);
    check("pre_rst_nz", out_data, 12'hA5B);
    #2 reset_n = 1'b0;
    #1 check("rst_async", out_data, 12'h000);
    @(negedge clock);
    check("rst_hold1", out_data, 12'h000);
    @(negedge clock);
    check("rst_hold2", out_data, 12'h000);
    reset_n = 1'b1;
    read_check("post_rst", 20'd1);

    // read-during-write, same and different addresses
    write_word(5, 12'h111);
    out_address = 20'd5; in_address = 11'd5; in_data = 12'h222; we = 1'b1;
    @(negedge clock);
    check("rdw_old", out_data, 12'h111);
    exp_mem[5] = 12'h222;
    in_address = 11'd6; in_data = 12'h444;
    @(negedge clock);
    we = 1'b0;
    check("rdw_new", out_data, 12'h222);
    exp_mem[6] = 12'h444;
    read_check("rdw_diff", 20'd6);

    // write disabled
    in_address = 11'd10; in_data = 12'h333; we = 1'b0;
    repeat (4) @(negedge clock);
    read_check("we_off", 20'd10);

    // reset in the middle of a load; writes during reset must be ignored
    for (int i = 0; i < 100; i++) write_word(i, 12'(i * 7 + 3));
    reset_n = 1'b0;
    in_address = 11'd0; in_data = 12'hBAD; we = 1'b1;
    #1 check("mid_rst_out", out_data, 12'h000);
    @(negedge clock);
    check("mid_rst_hold", out_data, 12'h000);
    @(negedge clock);
    we = 1'b0;
    reset_n = 1'b1;
    for (int i = 100; i < DEPTH; i++) write_word(i, 12'(i * 7 + 3));
    readback_all("mid_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
